irq_pend_ctrl: RTL and testbench

Interrupt-pending controller that sits directly upstream of the 8-to-3 priority encoder. It rising-edge-detects eight request lines and latches them into a pending register. It masks that register and presents it to the encoder's `I`/`EI` inputs. It also offers the highest-index enabled pending request to a consumer over a valid/ready handshake, clearing that pending bit on acceptance.

---
 rtl/irq_pkg.sv | 12 +
 rtl/prio_sel8.sv | 20 ++
 rtl/irq_pend_ctrl.sv | 90 +++++++++
 tb/tb_irq_pend_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt-pending controller and its priority selector.
package irq_pkg;

    localparam int NUM_SRC = 8;
    localparam int ID_W    = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } irq_state_t;

endpackage

// File: rtl/prio_sel8.sv
// Highest-set-index selector over an 8-bit vector, bit 7 wins.
// Purely combinational; no handshake.
module prio_sel8
    import irq_pkg::*;
(
    input  logic [NUM_SRC-1:0] vec,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    always_comb begin
        id  = '0;
        any = |vec;
        // Ascending scan so the last hit, i.e. the highest index, is kept.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (vec[i]) id = ID_W'(i);
        end
    end

endmodule

// File: rtl/irq_pend_ctrl.sv
// Edge-latched pending interrupts, masked into the encoder and offered over valid/ready.
// Latency: req edge -> pend 1 cycle, -> irq_valid 2 cycles; offer held frozen until irq_ready.
module irq_pend_ctrl
    import irq_pkg::*;
#(
    parameter logic [NUM_SRC-1:0] RESET_MASK = 8'hFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               en,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               clr_lost,
    output logic               irq_valid,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ready,
    output logic [NUM_SRC-1:0] pend,
    output logic [NUM_SRC-1:0] mask,
    output logic [NUM_SRC-1:0] lost,
    output logic [NUM_SRC-1:0] enc_I,
    output logic               enc_EI
);

    irq_state_t         state, state_nxt;
    logic [ID_W-1:0]    id_nxt;
    logic [NUM_SRC-1:0] req_d;
    logic [NUM_SRC-1:0] req_edge;
    logic [NUM_SRC-1:0] clr_vec;
    logic [NUM_SRC-1:0] lost_set;
    logic [ID_W-1:0]    sel_id;
    logic               sel_any;
    logic               accept;

    assign req_edge  = req & ~req_d;
    assign enc_I     = pend & mask;
    assign enc_EI    = en;
    assign irq_valid = (state == ST_OFFER);
    assign accept    = irq_valid & irq_ready;

    always_comb begin
        clr_vec = '0;
        if (accept) clr_vec[irq_id] = 1'b1;
    end

    // A bit being accepted this cycle cannot also overrun; a coincident edge just re-arms it.
    assign lost_set = req_edge & pend & ~clr_vec;

    prio_sel8 u_sel (
        .vec (enc_I),
        .id  (sel_id),
        .any (sel_any)
    );

    always_comb begin
        state_nxt = state;
        id_nxt    = irq_id;
        case (state)
            ST_IDLE: begin
                if (en && sel_any) begin
                    state_nxt = ST_OFFER;
                    id_nxt    = sel_id;
                end
            end
            ST_OFFER: begin
                if (irq_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            irq_id <= '0;
            req_d  <= '0;
            pend   <= '0;
            lost   <= '0;
            mask   <= RESET_MASK;
        end else begin
            state  <= state_nxt;
            irq_id <= id_nxt;
            req_d  <= req;
            pend   <= (pend & ~clr_vec) | req_edge;
            lost   <= (clr_lost ? '0 : lost) | lost_set;
            if (mask_we) mask <= mask_wdata;
        end
    end

endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Directed scenarios plus random traffic, every cycle compared against a behavioural model.
module tb_irq_pend_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       en;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       clr_lost;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic       irq_ready;
    logic [7:0] pend;
    logic [7:0] mask;
    logic [7:0] lost;
    logic [7:0] enc_I;
    logic       enc_EI;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit [7:0] m_pend, m_lost, m_mask, m_reqd;
    bit       m_valid;
    int       m_id;

    always #5 clk = ~clk;

    irq_pend_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .en         (en),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .clr_lost   (clr_lost),
        .irq_valid  (irq_valid),
        .irq_id     (irq_id),
        .irq_ready  (irq_ready),
        .pend       (pend),
        .mask       (mask),
        .lost       (lost),
        .enc_I      (enc_I),
        .enc_EI     (enc_EI)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Applies one clock edge to the model using the spec's per-source rules.
    task automatic model_edge();
        bit [7:0] np, nl;
        bit       nv;
        int       nid;
        if (rst) begin
            m_pend = 0; m_lost = 0; m_mask = 8'hFF; m_reqd = 0;
            m_valid = 0; m_id = 0;
            return;
        end
        np = m_pend; nl = clr_lost ? 8'h00 : m_lost;
        nv = m_valid; nid = m_id;
        for (int i = 0; i < 8; i++) begin
            bit e, c;
            e = req[i] && !m_reqd[i];
            c = m_valid && irq_ready && (m_id == i);
            if (c) np[i] = 1'b0;
            if (e) np[i] = 1'b1;
            if (e && m_pend[i] && !c) nl[i] = 1'b1;
        end
        if (m_valid) begin
            if (irq_ready) nv = 0;
        end else if (en && ((m_pend & m_mask) != 0)) begin
            nv = 1;
            for (int i = 0; i < 8; i++)
                if (m_pend[i] && m_mask[i]) nid = i;
        end
        m_pend = np; m_lost = nl; m_valid = nv; m_id = nid;
        if (mask_we) m_mask = mask_wdata;
        m_reqd = req;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("pend",   pend,      m_pend);
        check("lost",   lost,      m_lost);
        check("mask",   mask,      m_mask);
        check("valid",  irq_valid, m_valid);
        check("id",     irq_id,    m_id[2:0]);
        check("enc_I",  enc_I,     m_pend & m_mask);
        check("enc_EI", enc_EI,    en);
    endtask

    initial begin
        rst = 1; req = 0; en = 1; mask_we = 0; mask_wdata = 0; clr_lost = 0; irq_ready = 0;
        step(); step();
        check("rst_pend", pend, 8'h00);
        check("rst_mask", mask, 8'hFF);
        check("rst_valid", irq_valid, 1'b0);
        check("rst_enc_I", enc_I, 8'h00);

        // single request
        rst = 0; req = 8'h04;
        step(); check("t1_pend", pend, 8'h04); check("t1_valid0", irq_valid, 1'b0);
        step(); check("t1_valid", irq_valid, 1'b1); check("t1_id", irq_id, 3'd2);
        irq_ready = 1; step(); check("t1_acc_pend", pend, 8'h00); check("t1_acc_valid", irq_valid, 1'b0);
        irq_ready = 0; req = 0; step();

        // priority and freeze
        req = 8'h22; step(); step();
        check("t2_id5", irq_id, 3'd5);
        req = 8'hA2; step(); check("t2_frozen", irq_id, 3'd5); check("t2_pend", pend, 8'hA2);
        irq_ready = 1; step(); irq_ready = 0;
        step(); check("t2_id7", irq_id, 3'd7); check("t2_valid7", irq_valid, 1'b1);
        irq_ready = 1; step(); irq_ready = 0;
        step(); check("t2_id1", irq_id, 3'd1);
        irq_ready = 1; step(); irq_ready = 0; req = 0; step();

        // mask
        mask_we = 1; mask_wdata = 8'h7F; step(); mask_we = 0;
        req = 8'h80; step(); check("t3_pend", pend, 8'h80); check("t3_encI", enc_I, 8'h00);
        step(); check("t3_nooffer", irq_valid, 1'b0);
        mask_we = 1; mask_wdata = 8'hFF; step(); mask_we = 0;
        check("t3_still_idle", irq_valid, 1'b0);
        step(); check("t3_id7", irq_id, 3'd7); check("t3_valid", irq_valid, 1'b1);
        irq_ready = 1; step(); irq_ready = 0; req = 0; step();

        // overrun and simultaneity
        req = 8'h08; step(); step(); check("t4_offer3", irq_id, 3'd3);
        req = 0; step();
        req = 8'h08; step(); check("t4_lost", lost, 8'h08);
        req = 0; step();
        req = 8'h08; irq_ready = 1; step(); irq_ready = 0;
        check("t4_pend_kept", pend[3], 1'b1); check("t4_lost_same", lost, 8'h08);
        clr_lost = 1; step(); clr_lost = 0; check("t4_clr", lost, 8'h00);
        irq_ready = 1; req = 0; step(); step(); step(); step(); irq_ready = 0;

        // enable gating
        en = 0; req = 8'h11; step(); step();
        check("t5_nooffer", irq_valid, 1'b0); check("t5_EI", enc_EI, 1'b0);
        en = 1; step(); check("t5_id4", irq_id, 3'd4); check("t5_valid", irq_valid, 1'b1);
        en = 0; step(); check("t5_hold", irq_valid, 1'b1);
        irq_ready = 1; step(); irq_ready = 0; step();
        en = 1; irq_ready = 1; step(); step(); step(); irq_ready = 0; req = 0; step();

        // reset mid-offer
        req = 8'h40; step(); step(); check("t6_offer", irq_id, 3'd6);
        rst = 1; step(); rst = 0;
        check("t6_rst_valid", irq_valid, 1'b0); check("t6_rst_pend", pend, 8'h00);
        check("t6_rst_id", irq_id, 3'd0);
        step(); check("t6_fresh", pend, 8'h40);
        step(); check("t6_reoffer", irq_id, 3'd6);
        irq_ready = 1; step(); irq_ready = 0;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            req        = req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            en         = ($urandom_range(0, 9) != 0);
            mask_we    = ($urandom_range(0, 19) == 0);
            mask_wdata = 8'($urandom);
            clr_lost   = ($urandom_range(0, 29) == 0);
            irq_ready  = $urandom_range(0, 1) == 1;
            rst        = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
